// File: rtl/pdes_pkg.sv
// Shared PDES types: timestamp width, tagged (valid,time) pair and a clog2 helper.
package pdes_pkg;

  localparam int unsigned TIME_WID = 16;

  typedef logic [TIME_WID-1:0] time_t;

  typedef struct packed {
    logic  vld;
    time_t tm;
  } tagged_time_t;

  // Ceiling log2 usable in constant expressions; clog2(1) = 0.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned p = 1; p < v; p = p << 1) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/gvt_tracker_if.sv
// Bundle of per-core/event-queue inputs and GVT outputs for the tracker.
interface gvt_tracker_if #(
  parameter int unsigned NUM_CORE = 8,
  parameter int unsigned TIME_WID = 16
);
  logic [TIME_WID*NUM_CORE-1:0] core_times;
  logic [NUM_CORE-1:0]          core_vld;
  logic [TIME_WID-1:0]          next_event;
  logic                         next_event_vld;
  logic [TIME_WID-1:0]          gvt;
  logic                         gvt_vld;
  logic                         gvt_adv;
  logic                         idle;
  logic                         regress_err;

  modport master (
    output core_times, core_vld, next_event, next_event_vld,
    input  gvt, gvt_vld, gvt_adv, idle, regress_err
  );

  modport slave (
    input  core_times, core_vld, next_event, next_event_vld,
    output gvt, gvt_vld, gvt_adv, idle, regress_err
  );
endinterface

// File: rtl/gvt_tracker_min_node.sv
// Registered two-input tagged-time minimum; ties and equal times favour input a.
module gvt_min_node #(
  parameter int unsigned TIME_WID = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                a_vld,
  input  logic [TIME_WID-1:0] a_t,
  input  logic                b_vld,
  input  logic [TIME_WID-1:0] b_t,
  output logic                y_vld,
  output logic [TIME_WID-1:0] y_t
);

  logic                y_vld_d, y_vld_q;
  logic [TIME_WID-1:0] y_t_d, y_t_q;

  // Select the smaller valid input; an all-invalid pair yields invalid time 0.
  always_comb begin
    y_vld_d = 1'b0;
    y_t_d   = '0;
    if (a_vld && b_vld) begin
      y_vld_d = 1'b1;
      y_t_d   = (b_t < a_t) ? b_t : a_t;
    end else if (a_vld) begin
      y_vld_d = 1'b1;
      y_t_d   = a_t;
    end else if (b_vld) begin
      y_vld_d = 1'b1;
      y_t_d   = b_t;
    end
  end

  // Pipeline register; reset clears the valid bit so in-flight samples are dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      y_vld_q <= 1'b0;
      y_t_q   <= '0;
    end else begin
      y_vld_q <= y_vld_d;
      y_t_q   <= y_t_d;
    end
  end

  assign y_vld = y_vld_q;
  assign y_t   = y_t_q;

endmodule

// File: rtl/gvt_tracker.sv
// Pipelined GVT tracker: registered min-tree over cores + queue head, then a monotonic update stage.
module gvt_tracker #(
  parameter int unsigned NUM_CORE = 8,
  parameter int unsigned TIME_WID = 16
) (
  input logic          clk,
  input logic          rst,
  gvt_tracker_if.slave bus
);
  import pdes_pkg::*;

  localparam int unsigned LEVELS = clog2(NUM_CORE + 1);
  localparam int unsigned N_LEAF = 32'(1) << LEVELS;
  localparam int unsigned N_NODE = N_LEAF - 1;

  // Leaves are heap slots N_NODE..2*N_NODE; node g has children 2g+1 and 2g+2.
  logic                leaf_vld [N_LEAF];
  logic [TIME_WID-1:0] leaf_t   [N_LEAF];
  logic                node_vld [N_NODE];
  logic [TIME_WID-1:0] node_t   [N_NODE];

  for (genvar g = 0; g < N_LEAF; g++) begin : g_leaf
    if (g < NUM_CORE) begin : g_core
      assign leaf_vld[g] = bus.core_vld[g];
      assign leaf_t[g]   = bus.core_times[TIME_WID*g +: TIME_WID];
    end else if (g == NUM_CORE) begin : g_queue
      assign leaf_vld[g] = bus.next_event_vld;
      assign leaf_t[g]   = bus.next_event;
    end else begin : g_pad
      assign leaf_vld[g] = 1'b0;
      assign leaf_t[g]   = '0;
    end
  end

  for (genvar g = 0; g < N_NODE; g++) begin : g_node
    localparam int unsigned CA = 2*g + 1;
    localparam int unsigned CB = 2*g + 2;
    if (CA >= N_NODE) begin : g_from_leaf
      gvt_min_node #(.TIME_WID(TIME_WID)) u_node (
        .clk   (clk),
        .rst   (rst),
        .a_vld (leaf_vld[CA-N_NODE]),
        .a_t   (leaf_t[CA-N_NODE]),
        .b_vld (leaf_vld[CB-N_NODE]),
        .b_t   (leaf_t[CB-N_NODE]),
        .y_vld (node_vld[g]),
        .y_t   (node_t[g])
      );
    end else begin : g_from_node
      gvt_min_node #(.TIME_WID(TIME_WID)) u_node (
        .clk   (clk),
        .rst   (rst),
        .a_vld (node_vld[CA]),
        .a_t   (node_t[CA]),
        .b_vld (node_vld[CB]),
        .b_t   (node_t[CB]),
        .y_vld (node_vld[g]),
        .y_t   (node_t[g])
      );
    end
  end

  logic                cand_vld;
  logic [TIME_WID-1:0] cand_t;
  assign cand_vld = node_vld[0];
  assign cand_t   = node_t[0];

  logic [TIME_WID-1:0] gvt_d, gvt_q;
  logic                gvt_vld_d, gvt_vld_q;
  logic                gvt_adv_d, gvt_adv_q;
  logic                idle_d, idle_q;
  logic                regress_err_d, regress_err_q;

  // Update rule: gvt only moves forward; a lower candidate sets the sticky error.
  always_comb begin
    gvt_d         = gvt_q;
    gvt_vld_d     = gvt_vld_q;
    gvt_adv_d     = 1'b0;
    idle_d        = 1'b1;
    regress_err_d = regress_err_q;
    if (cand_vld) begin
      idle_d = 1'b0;
      if (!gvt_vld_q || (cand_t > gvt_q)) begin
        gvt_d     = cand_t;
        gvt_vld_d = 1'b1;
        gvt_adv_d = 1'b1;
      end else if (cand_t < gvt_q) begin
        regress_err_d = 1'b1;
      end
    end
  end

  // Output/state register for the update stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      gvt_q         <= '0;
      gvt_vld_q     <= 1'b0;
      gvt_adv_q     <= 1'b0;
      idle_q        <= 1'b1;
      regress_err_q <= 1'b0;
    end else begin
      gvt_q         <= gvt_d;
      gvt_vld_q     <= gvt_vld_d;
      gvt_adv_q     <= gvt_adv_d;
      idle_q        <= idle_d;
      regress_err_q <= regress_err_d;
    end
  end

  assign bus.gvt         = gvt_q;
  assign bus.gvt_vld     = gvt_vld_q;
  assign bus.gvt_adv     = gvt_adv_q;
  assign bus.idle        = idle_q;
  assign bus.regress_err = regress_err_q;

endmodule

// File: tb/tb_gvt_tracker.sv
// Bench for gvt_tracker: NUM_CORE=8 and NUM_CORE=5 instances against a queue-delayed reference model.
module tb_gvt_tracker;
  import pdes_pkg::*;

  localparam int L8 = 4;
  localparam int L5 = 3;

  typedef struct packed {
    logic [15:0] gvt;
    logic        vld;
    logic        adv;
    logic        idle;
    logic        err;
  } mdl_t;

  localparam mdl_t         M_RST = '{gvt: 16'h0, vld: 1'b0, adv: 1'b0, idle: 1'b1, err: 1'b0};
  localparam tagged_time_t NO_S  = '{vld: 1'b0, tm: 16'h0};

  logic clk = 1'b0;
  logic rst8, rst5;
  int   n_chk = 0;
  int   n_err = 0;

  tagged_time_t q8[$];
  tagged_time_t q5[$];
  mdl_t         m8 = M_RST;
  mdl_t         m5 = M_RST;

  gvt_tracker_if #(.NUM_CORE(8), .TIME_WID(16)) if8 ();
  gvt_tracker_if #(.NUM_CORE(5), .TIME_WID(16)) if5 ();

  gvt_tracker #(.NUM_CORE(8), .TIME_WID(16)) dut8 (.clk(clk), .rst(rst8), .bus(if8.slave));
  gvt_tracker #(.NUM_CORE(5), .TIME_WID(16)) dut5 (.clk(clk), .rst(rst5), .bus(if5.slave));

  always #5 clk = ~clk;

  function automatic tagged_time_t samp(input logic [127:0] t, input logic [7:0] v, input int n,
                                        input logic [15:0] ne, input logic nv);
    tagged_time_t r;
    r = NO_S;
    for (int i = 0; i < n; i++) begin
      if (v[i] && (!r.vld || t[16*i +: 16] < r.tm)) begin
        r.vld = 1'b1;
        r.tm  = t[16*i +: 16];
      end
    end
    if (nv && (!r.vld || ne < r.tm)) begin
      r.vld = 1'b1;
      r.tm  = ne;
    end
    return r;
  endfunction

  function automatic mdl_t upd(input mdl_t m, input tagged_time_t s);
    mdl_t r;
    r      = m;
    r.adv  = 1'b0;
    r.idle = 1'b1;
    if (s.vld) begin
      r.idle = 1'b0;
      if (!m.vld || s.tm > m.gvt) begin
        r.gvt = s.tm;
        r.vld = 1'b1;
        r.adv = 1'b1;
      end else if (s.tm < m.gvt) begin
        r.err = 1'b1;
      end
    end
    return r;
  endfunction

  // One clock edge: push the sampled expectation, retire the one LEVELS edges old, sample at +1.
  task automatic tick();
    tagged_time_t s;
    @(posedge clk);
    s = samp(if8.core_times, if8.core_vld, 8, if8.next_event, if8.next_event_vld);
    if (rst8) begin
      q8.delete();
      m8 = M_RST;
    end else begin
      q8.push_back(s);
      if (q8.size() > L8) m8 = upd(m8, q8.pop_front());
      else m8 = upd(m8, NO_S);
    end
    s = samp(128'(if5.core_times), 8'(if5.core_vld), 5, if5.next_event, if5.next_event_vld);
    if (rst5) begin
      q5.delete();
      m5 = M_RST;
    end else begin
      q5.push_back(s);
      if (q5.size() > L5) m5 = upd(m5, q5.pop_front());
      else m5 = upd(m5, NO_S);
    end
    #1;
  endtask

  task automatic test_reset();
    rst8 = 1'b1;
    rst5 = 1'b1;
    tick();
    tick();
    n_chk++;
    if ({if8.gvt, if8.gvt_vld, if8.gvt_adv, if8.idle, if8.regress_err} !== {16'h0, 4'b0010}) begin
      n_err++;
      $display("FAIL reset8 got=%h exp=%h", {if8.gvt, if8.gvt_vld, if8.gvt_adv, if8.idle, if8.regress_err}, {16'h0, 4'b0010});
    end
    n_chk++;
    if ({if5.gvt, if5.gvt_vld, if5.gvt_adv, if5.idle, if5.regress_err} !== {16'h0, 4'b0010}) begin
      n_err++;
      $display("FAIL reset5 got=%h exp=%h", {if5.gvt, if5.gvt_vld, if5.gvt_adv, if5.idle, if5.regress_err}, {16'h0, 4'b0010});
    end
    rst8 = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      n_chk++;
      if ({if8.gvt_vld, if8.gvt_adv, if8.idle} !== 3'b001) begin
        n_err++;
        $display("FAIL idle_hold cyc=%0d got vld/adv/idle=%b exp=001", i, {if8.gvt_vld, if8.gvt_adv, if8.idle});
      end
    end
  endtask

  task automatic test_first_value();
    if8.next_event     = 16'h10;
    if8.next_event_vld = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      n_chk++;
      if ({if8.gvt, if8.gvt_vld, if8.gvt_adv, if8.idle, if8.regress_err} !== m8) begin
        n_err++;
        $display("FAIL first_model cyc=%0d got=%h exp=%h", i, {if8.gvt, if8.gvt_vld, if8.gvt_adv, if8.idle, if8.regress_err}, m8);
      end
      n_chk++;
      if (i < 4 && if8.gvt_vld !== 1'b0) begin
        n_err++;
        $display("FAIL first_early cyc=%0d got gvt_vld=%b exp=0", i, if8.gvt_vld);
      end else if (i == 4 && {if8.gvt, if8.gvt_vld, if8.gvt_adv, if8.idle} !== {16'h10, 3'b110}) begin
        n_err++;
        $display("FAIL first_value got=%h exp=%h", {if8.gvt, if8.gvt_vld, if8.gvt_adv, if8.idle}, {16'h10, 3'b110});
      end else if (i == 5 && if8.gvt_adv !== 1'b0) begin
        n_err++;
        $display("FAIL first_pulse got gvt_adv=%b exp=0", if8.gvt_adv);
      end
    end
  endtask

  task automatic test_advance();
    int adv_cnt;
    for (int ph = 0; ph < 2; ph++) begin
      adv_cnt = 0;
      if (ph == 0) begin
        if8.next_event         = 16'h20;
        if8.core_vld[3]        = 1'b1;
        if8.core_times[48 +: 16] = 16'h18;
      end else begin
        if8.core_vld[3] = 1'b0;
      end
      for (int i = 0; i < 8; i++) begin
        tick();
        adv_cnt += int'(if8.gvt_adv);
        n_chk++;
        if ({if8.gvt, if8.gvt_vld, if8.gvt_adv, if8.idle, if8.regress_err} !== m8) begin
          n_err++;
          $display("FAIL adv_model ph=%0d cyc=%0d got=%h exp=%h", ph, i, {if8.gvt, if8.gvt_vld, if8.gvt_adv, if8.idle, if8.regress_err}, m8);
        end
      end
      n_chk++;
      if (if8.gvt !== ((ph == 0) ? 16'h18 : 16'h20) || adv_cnt != 1) begin
        n_err++;
        $display("FAIL advance ph=%0d got gvt=%h pulses=%0d exp gvt=%h pulses=1", ph, if8.gvt, adv_cnt, (ph == 0) ? 16'h18 : 16'h20);
      end
    end
  endtask

  task automatic test_regression();
    for (int ph = 0; ph < 2; ph++) begin
      if8.core_vld[6]          = (ph == 0);
      if8.core_times[96 +: 16] = 16'h12;
      for (int i = 0; i < 8; i++) begin
        tick();
        n_chk++;
        if ({if8.gvt, if8.gvt_vld, if8.gvt_adv, if8.idle, if8.regress_err} !== m8) begin
          n_err++;
          $display("FAIL regr_model ph=%0d cyc=%0d got=%h exp=%h", ph, i, {if8.gvt, if8.gvt_vld, if8.gvt_adv, if8.idle, if8.regress_err}, m8);
        end
      end
      n_chk++;
      if (if8.gvt !== 16'h20 || if8.regress_err !== 1'b1) begin
        n_err++;
        $display("FAIL regress ph=%0d got gvt=%h err=%b exp gvt=0020 err=1", ph, if8.gvt, if8.regress_err);
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 16; i++) begin
      if8.next_event = 16'(16'h30 + i);
      tick();
      n_chk++;
      if ({if8.gvt, if8.gvt_vld, if8.gvt_adv, if8.idle, if8.regress_err} !== m8) begin
        n_err++;
        $display("FAIL b2b_model cyc=%0d got=%h exp=%h", i, {if8.gvt, if8.gvt_vld, if8.gvt_adv, if8.idle, if8.regress_err}, m8);
      end
      if (i >= 4) begin
        n_chk++;
        if (if8.gvt !== 16'(16'h30 + i - 4) || if8.gvt_adv !== 1'b1) begin
          n_err++;
          $display("FAIL b2b cyc=%0d got gvt=%h adv=%b exp gvt=%h adv=1", i, if8.gvt, if8.gvt_adv, 16'(16'h30 + i - 4));
        end
      end
    end
  endtask

  task automatic test_max_and_reset();
    if8.next_event_vld = 1'b0;
    if8.core_vld       = 8'hFF;
    if8.core_times     = {8{16'hFFFF}};
    for (int i = 0; i < 7; i++) begin
      tick();
      n_chk++;
      if ({if8.gvt, if8.gvt_vld, if8.gvt_adv, if8.idle, if8.regress_err} !== m8) begin
        n_err++;
        $display("FAIL max_model cyc=%0d got=%h exp=%h", i, {if8.gvt, if8.gvt_vld, if8.gvt_adv, if8.idle, if8.regress_err}, m8);
      end
    end
    n_chk++;
    if (if8.gvt !== 16'hFFFF || if8.gvt_vld !== 1'b1) begin
      n_err++;
      $display("FAIL max_time got gvt=%h vld=%b exp gvt=ffff vld=1", if8.gvt, if8.gvt_vld);
    end
    rst8 = 1'b1;
    tick();
    rst8 = 1'b0;
    n_chk++;
    if ({if8.gvt, if8.gvt_vld, if8.regress_err} !== 18'h0) begin
      n_err++;
      $display("FAIL rst_clear got gvt=%h vld=%b err=%b exp all 0", if8.gvt, if8.gvt_vld, if8.regress_err);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      n_chk++;
      if (i < 4 && if8.gvt_vld !== 1'b0) begin
        n_err++;
        $display("FAIL refill cyc=%0d got gvt_vld=%b exp=0", i, if8.gvt_vld);
      end else if (i == 4 && (if8.gvt !== 16'hFFFF || if8.gvt_adv !== 1'b1)) begin
        n_err++;
        $display("FAIL refill_val got gvt=%h adv=%b exp gvt=ffff adv=1", if8.gvt, if8.gvt_adv);
      end
    end
  endtask

  task automatic test_nonpow2();
    if5.core_times     = {16'h7, 16'h50, 16'h20, 16'h30, 16'h40};
    if5.core_vld       = 5'h1F;
    if5.next_event     = 16'h60;
    if5.next_event_vld = 1'b1;
    rst5 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_chk++;
      if ({if5.gvt, if5.gvt_vld, if5.gvt_adv, if5.idle, if5.regress_err} !== m5) begin
        n_err++;
        $display("FAIL np2_model cyc=%0d got=%h exp=%h", i, {if5.gvt, if5.gvt_vld, if5.gvt_adv, if5.idle, if5.regress_err}, m5);
      end
      n_chk++;
      if (i < 3 && if5.gvt_vld !== 1'b0) begin
        n_err++;
        $display("FAIL np2_early cyc=%0d got gvt_vld=%b exp=0", i, if5.gvt_vld);
      end else if (i == 3 && {if5.gvt, if5.gvt_vld, if5.gvt_adv} !== {16'h7, 2'b11}) begin
        n_err++;
        $display("FAIL np2_value got=%h exp=%h", {if5.gvt, if5.gvt_vld, if5.gvt_adv}, {16'h7, 2'b11});
      end else if (i == 4 && if5.gvt !== 16'h7) begin
        n_err++;
        $display("FAIL np2_hold got gvt=%h exp=0007", if5.gvt);
      end
    end
    if5.core_times[64 +: 16] = 16'h8;
    tick();
    tick();
    rst5 = 1'b1;
    tick();
    n_chk++;
    if (if5.gvt !== 16'h0 || if5.gvt_vld !== 1'b0) begin
      n_err++;
      $display("FAIL mid_rst got gvt=%h vld=%b exp gvt=0000 vld=0", if5.gvt, if5.gvt_vld);
    end
    rst5               = 1'b0;
    if5.core_vld       = 5'h0;
    if5.next_event_vld = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      n_chk++;
      if (if5.gvt_vld !== 1'b0 || if5.gvt_adv !== 1'b0 || if5.gvt !== 16'h0) begin
        n_err++;
        $display("FAIL stale cyc=%0d got gvt=%h vld=%b adv=%b exp 0/0/0", i, if5.gvt, if5.gvt_vld, if5.gvt_adv);
      end
    end
  endtask

  initial begin
    rst8               = 1'b1;
    rst5               = 1'b1;
    if8.core_times     = '0;
    if8.core_vld       = '0;
    if8.next_event     = '0;
    if8.next_event_vld = 1'b0;
    if5.core_times     = '0;
    if5.core_vld       = '0;
    if5.next_event     = '0;
    if5.next_event_vld = 1'b0;
    test_reset();
    test_first_value();
    test_advance();
    test_regression();
    test_back_to_back();
    test_max_and_reset();
    test_nonpow2();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
